kfmmc_block_data_io: RTL and testbench

KFMMC_BLOCK_DATA_IO -- requirements
Module: kfmmc_block_data_io

---
 rtl/kfmmc_data_pkg.sv | 17 +
 rtl/kfmmc_data_timeout.sv | 27 ++
 rtl/kfmmc_block_data_io.sv | 174 +++++++++++++++++
 tb/tb_kfmmc_block_data_io.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kfmmc_data_pkg.sv
// Shared types for the KFMMC block data mover: FSM states and transfer
// direction encodings.
package kfmmc_data_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ARM,
        ISSUE,
        WAIT_ACK,
        DONE
    } state_t;

    localparam logic DIR_SEND = 1'b0;
    localparam logic DIR_RECV = 1'b1;

endpackage

// File: rtl/kfmmc_data_timeout.sv
// First-byte receive watchdog: counts enabled cycles and flags expiry once
// LIMIT cycles have elapsed. Only built with KFMMC_DATA_TIMEOUT_EN.
module kfmmc_data_timeout #(
    parameter logic [15:0] LIMIT = 16'hFFFF
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    logic [15:0] count;

    assign expired = enable && (count == LIMIT - 16'd1);

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/kfmmc_block_data_io.sv
// Block-level data mover between a byte stream and the KFMMC byte engine.
// Optional first-byte receive timeout: define KFMMC_DATA_TIMEOUT_EN.
module kfmmc_block_data_io
    import kfmmc_data_pkg::*;
#(
    parameter int          LEN_W         = 9,
    parameter logic [15:0] TIMEOUT_LIMIT = 16'hFFFF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             disable_data_io,
    input  logic             start_block,
    input  logic             direction,
    input  logic [LEN_W-1:0] block_length,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             done,
    output logic             timeout_error,
    output logic [LEN_W:0]   byte_count,
    output logic             start_communication_to_mmc,
    output logic             data_io_to_mmc,
    output logic             check_data_start_bit_to_mmc,
    output logic             clear_data_crc_to_mmc,
    output logic             clear_data_interrupt_to_mmc,
    output logic             mask_data_interrupt_to_mmc,
    output logic             set_send_data_to_mmc,
    output logic [7:0]       send_data_to_mmc,
    input  logic [7:0]       received_data_from_mmc,
    input  logic             mmc_is_in_connecting,
    input  logic             sent_data_interrupt_from_mmc,
    input  logic             received_data_interrupt_from_mmc
);

    state_t           state, next;
    logic             dir_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W:0]   eff_len;
    logic [LEN_W:0]   cnt_inc;
    logic             irq;
    logic             expired;

    // A zero length encodes the full 2**LEN_W byte block.
    assign eff_len = (len_q == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len_q};
    assign cnt_inc = byte_count + 1'b1;
    assign irq     = (dir_q == DIR_RECV) ? received_data_interrupt_from_mmc
                                         : sent_data_interrupt_from_mmc;
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);

`ifdef KFMMC_DATA_TIMEOUT_EN
    logic to_en;

    assign to_en = (state == WAIT_ACK) && (dir_q == DIR_RECV)
                && (byte_count == '0);

    kfmmc_data_timeout #(
        .LIMIT   (TIMEOUT_LIMIT)
    ) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .enable  (to_en),
        .clear   (!to_en),
        .expired (expired)
    );

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            timeout_error <= 1'b0;
        end else if (!disable_data_io) begin
            if (state == IDLE && start_block)
                timeout_error <= 1'b0;
            else if (state == WAIT_ACK && !irq && expired)
                timeout_error <= 1'b1;
        end
    end
`else
    assign expired       = 1'b0;
    assign timeout_error = 1'b0;
`endif

    always_comb begin
        next                        = state;
        tx_ready                    = 1'b0;
        start_communication_to_mmc  = 1'b0;
        data_io_to_mmc              = 1'b1;
        check_data_start_bit_to_mmc = 1'b0;
        clear_data_crc_to_mmc       = 1'b0;
        clear_data_interrupt_to_mmc = 1'b0;
        set_send_data_to_mmc        = 1'b0;
        if (disable_data_io) begin
            next = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_block)
                        next = (direction == DIR_RECV) ? ARM : LOAD;
                end
                LOAD: begin
                    if (tx_valid) begin
                        tx_ready = 1'b1;
                        next     = ARM;
                    end
                end
                ARM: begin
                    if (!mmc_is_in_connecting)
                        next = ISSUE;
                end
                ISSUE: begin
                    start_communication_to_mmc  = 1'b1;
                    clear_data_interrupt_to_mmc = 1'b1;
                    data_io_to_mmc              = dir_q;
                    set_send_data_to_mmc        = ~dir_q;
                    clear_data_crc_to_mmc       = (byte_count == '0);
                    check_data_start_bit_to_mmc = (dir_q == DIR_RECV)
                                               && (byte_count == '0);
                    if (mmc_is_in_connecting)
                        next = WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (irq) begin
                        if (cnt_inc == eff_len)
                            next = DONE;
                        else
                            next = (dir_q == DIR_RECV) ? ARM : LOAD;
                    end else if (expired) begin
                        next = DONE;
                    end
                end
                DONE:    next = IDLE;
                default: next = IDLE;
            endcase
        end
    end

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            state                      <= IDLE;
            dir_q                      <= DIR_SEND;
            len_q                      <= '0;
            byte_count                 <= '0;
            send_data_to_mmc           <= 8'h00;
            rx_data                    <= 8'h00;
            rx_valid                   <= 1'b0;
            mask_data_interrupt_to_mmc <= 1'b0;
        end else begin
            state    <= next;
            rx_valid <= 1'b0;
            if (disable_data_io) begin
                mask_data_interrupt_to_mmc <= 1'b1;
            end else begin
                if (state == IDLE && start_block) begin
                    byte_count                 <= '0;
                    dir_q                      <= direction;
                    len_q                      <= block_length;
                    mask_data_interrupt_to_mmc <= 1'b0;
                end
                if (state == LOAD && tx_valid)
                    send_data_to_mmc <= tx_data;
                if (state == WAIT_ACK && irq) begin
                    byte_count <= cnt_inc;
                    if (dir_q == DIR_RECV) begin
                        rx_data  <= received_data_from_mmc;
                        rx_valid <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_kfmmc_block_data_io.sv
// Directed bench for kfmmc_block_data_io (LEN_W=2, TIMEOUT_LIMIT=8) with a
// simple byte-engine model; timeout cases need KFMMC_DATA_TIMEOUT_EN.
module tb_kfmmc_block_data_io;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       disable_data_io = 1'b0;
    logic       start_block = 1'b0;
    logic       direction = 1'b0;
    logic [1:0] block_length = 2'd0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       done;
    logic       timeout_error;
    logic [2:0] byte_count;
    logic       start_communication_to_mmc;
    logic       data_io_to_mmc;
    logic       check_data_start_bit_to_mmc;
    logic       clear_data_crc_to_mmc;
    logic       clear_data_interrupt_to_mmc;
    logic       mask_data_interrupt_to_mmc;
    logic       set_send_data_to_mmc;
    logic [7:0] send_data_to_mmc;
    logic [7:0] received_data_from_mmc = 8'h00;
    logic       mmc_is_in_connecting = 1'b0;
    logic       sent_irq = 1'b0;
    logic       recv_irq = 1'b0;

    int n_chk = 0;
    int n_fail = 0;
    int tx_idx = 0;
    int done_cnt = 0;
    logic [7:0] tx_mem [4];
    logic [7:0] rx_q [$];
    logic [7:0] sd_q [$];
    logic       crc_q [$];
    logic       csb_q [$];
    logic       dio_q [$];

    kfmmc_block_data_io #(
        .LEN_W                            (2),
        .TIMEOUT_LIMIT                    (16'd8)
    ) dut (
        .clock                            (clock),
        .reset                            (reset),
        .disable_data_io                  (disable_data_io),
        .start_block                      (start_block),
        .direction                        (direction),
        .block_length                     (block_length),
        .tx_data                          (tx_data),
        .tx_valid                         (tx_valid),
        .tx_ready                         (tx_ready),
        .rx_data                          (rx_data),
        .rx_valid                         (rx_valid),
        .busy                             (busy),
        .done                             (done),
        .timeout_error                    (timeout_error),
        .byte_count                       (byte_count),
        .start_communication_to_mmc       (start_communication_to_mmc),
        .data_io_to_mmc                   (data_io_to_mmc),
        .check_data_start_bit_to_mmc      (check_data_start_bit_to_mmc),
        .clear_data_crc_to_mmc            (clear_data_crc_to_mmc),
        .clear_data_interrupt_to_mmc      (clear_data_interrupt_to_mmc),
        .mask_data_interrupt_to_mmc       (mask_data_interrupt_to_mmc),
        .set_send_data_to_mmc             (set_send_data_to_mmc),
        .send_data_to_mmc                 (send_data_to_mmc),
        .received_data_from_mmc           (received_data_from_mmc),
        .mmc_is_in_connecting             (mmc_is_in_connecting),
        .sent_data_interrupt_from_mmc     (sent_irq),
        .received_data_interrupt_from_mmc (recv_irq)
    );

    always #5 clock = ~clock;

    // DUT updates on the falling edge; observe on the rising edge.
    always @(posedge clock) begin
        if (tx_ready) tx_idx++;
        if (rx_valid) rx_q.push_back(rx_data);
        if (done) done_cnt++;
    end

    always @(negedge clock) begin
        #2;
        tx_data = tx_mem[tx_idx % 4];
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start(input logic dir, input logic [1:0] len);
        direction    = dir;
        block_length = len;
        start_block  = 1'b1;
        tick();
        start_block  = 1'b0;
    endtask

    task automatic clear_logs();
        rx_q.delete();
        sd_q.delete();
        crc_q.delete();
        csb_q.delete();
        dio_q.delete();
        tx_idx = 0;
    endtask

    // Byte engine: accept an issue, then acknowledge with an interrupt.
    task automatic engine_byte(input logic [7:0] rdata, input logic recv);
        int k;
        k = 0;
        while (!start_communication_to_mmc && k < 50) begin
            tick();
            k++;
        end
        if (!start_communication_to_mmc) begin
            chk("issue_seen", 0, 1);
            return;
        end
        sd_q.push_back(send_data_to_mmc);
        crc_q.push_back(clear_data_crc_to_mmc);
        csb_q.push_back(check_data_start_bit_to_mmc);
        dio_q.push_back(data_io_to_mmc);
        received_data_from_mmc = rdata;
        mmc_is_in_connecting = 1'b1;
        tick();
        mmc_is_in_connecting = 1'b0;
        if (recv) recv_irq = 1'b1;
        else sent_irq = 1'b1;
        tick();
        recv_irq = 1'b0;
        sent_irq = 1'b0;
    endtask

    task automatic check_reset_values(input string pfx);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_done"}, done, 0);
        chk({pfx, "_bytes"}, byte_count, 0);
        chk({pfx, "_sdata"}, send_data_to_mmc, 0);
        chk({pfx, "_rdata"}, rx_data, 0);
        chk({pfx, "_dio"}, data_io_to_mmc, 1);
        chk({pfx, "_mask"}, mask_data_interrupt_to_mmc, 0);
        chk({pfx, "_start"}, start_communication_to_mmc, 0);
        chk({pfx, "_txrdy"}, tx_ready, 0);
        chk({pfx, "_rxv"}, rx_valid, 0);
        chk({pfx, "_tmo"}, timeout_error, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int k;
        tx_mem[0] = 8'h11;
        tx_mem[1] = 8'h22;
        tx_mem[2] = 8'h33;
        tx_mem[3] = 8'h44;
        tick();
        tick();
        check_reset_values("rst");
        reset = 1'b0;
        tick();

        // Send four bytes with block_length=0 (2**LEN_W bytes).
        clear_logs();
        tx_valid = 1'b1;
        d0 = done_cnt;
        start(1'b0, 2'd0);
        for (int i = 0; i < 4; i++) engine_byte(8'h00, 1'b0);
        tick();
        tick();
        tx_valid = 1'b0;
        chk("snd_txrdy", tx_idx, 4);
        chk("snd_done", done_cnt - d0, 1);
        chk("snd_bytes", byte_count, 4);
        chk("snd_busy", busy, 0);
        chk("snd_n", sd_q.size(), 4);
        if (sd_q.size() == 4) begin
            chk("snd_d0", sd_q[0], 8'h11);
            chk("snd_d1", sd_q[1], 8'h22);
            chk("snd_d2", sd_q[2], 8'h33);
            chk("snd_d3", sd_q[3], 8'h44);
            chk("snd_crc", {crc_q[0], crc_q[1], crc_q[2], crc_q[3]}, 4'b1000);
            chk("snd_csb", {csb_q[0], csb_q[1], csb_q[2], csb_q[3]}, 4'b0000);
            chk("snd_dio", {dio_q[0], dio_q[1], dio_q[2], dio_q[3]}, 4'b0000);
        end

        // Receive three bytes.
        clear_logs();
        d0 = done_cnt;
        start(1'b1, 2'd3);
        engine_byte(8'hA5, 1'b1);
        engine_byte(8'h5A, 1'b1);
        engine_byte(8'hFF, 1'b1);
        tick();
        tick();
        chk("rcv_n", rx_q.size(), 3);
        if (rx_q.size() == 3) begin
            chk("rcv_d0", rx_q[0], 8'hA5);
            chk("rcv_d1", rx_q[1], 8'h5A);
            chk("rcv_d2", rx_q[2], 8'hFF);
        end
        if (csb_q.size() == 3) begin
            chk("rcv_csb", {csb_q[0], csb_q[1], csb_q[2]}, 3'b100);
            chk("rcv_dio", {dio_q[0], dio_q[1], dio_q[2]}, 3'b111);
        end
        chk("rcv_done", done_cnt - d0, 1);
        chk("rcv_bytes", byte_count, 3);
        chk("rcv_tx", tx_idx, 0);

        // Interrupts while idle must not count.
        sent_irq = 1'b1;
        recv_irq = 1'b1;
        tick();
        sent_irq = 1'b0;
        recv_irq = 1'b0;
        tick();
        chk("idle_irq_bytes", byte_count, 3);
        chk("idle_irq_rx", rx_q.size(), 3);

        // Abort after byte 2 of 4.
        clear_logs();
        tx_valid = 1'b1;
        d0 = done_cnt;
        start(1'b0, 2'd0);
        engine_byte(8'h00, 1'b0);
        engine_byte(8'h00, 1'b0);
        disable_data_io = 1'b1;
        tick();
        chk("dis_busy", busy, 0);
        chk("dis_mask", mask_data_interrupt_to_mmc, 1);
        chk("dis_start", start_communication_to_mmc, 0);
        chk("dis_bytes", byte_count, 2);
        tx_valid = 1'b0;
        disable_data_io = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("dis_done", done_cnt - d0, 0);
        chk("dis_idle", busy, 0);

`ifdef KFMMC_DATA_TIMEOUT_EN
        // First receive byte never acknowledged.
        d0 = done_cnt;
        start(1'b1, 2'd1);
        k = 0;
        while (!start_communication_to_mmc && k < 50) begin
            tick();
            k++;
        end
        mmc_is_in_connecting = 1'b1;
        tick();
        mmc_is_in_connecting = 1'b0;
        k = 0;
        while (!done && k < 40) begin
            tick();
            k++;
        end
        chk("tmo_cycles", k, 8);
        chk("tmo_err", timeout_error, 1);
        tick();
        tick();
        chk("tmo_done", done_cnt - d0, 1);
        chk("tmo_sticky", timeout_error, 1);
        start(1'b1, 2'd1);
        chk("tmo_clear", timeout_error, 0);
        disable_data_io = 1'b1;
        tick();
        disable_data_io = 1'b0;
        tick();
`else
        chk("tmo_tied", timeout_error, 0);
`endif

        // Start while busy is ignored; then reset mid-send.
        clear_logs();
        d0 = done_cnt;
        start(1'b0, 2'd0);
        chk("bsy_busy", busy, 1);
        start(1'b1, 2'd1);
        tx_valid = 1'b1;
        engine_byte(8'h00, 1'b0);
        if (dio_q.size() == 1) chk("bsy_dir", dio_q[0], 0);
        chk("bsy_bytes", byte_count, 1);
        tick();
        reset = 1'b1;
        #1;
        tx_valid = 1'b1;
        #1;
        check_reset_values("mid");
        tick();
        reset = 1'b0;
        tx_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("mid_done", done_cnt - d0, 0);
        chk("mid_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
